// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry
// Debounced 10-key decimal pad front end. Every accepted press is encoded to
// BCD, offered on a valid/ready digit stream and shifted into a DIGITS-wide
// BCD entry register. The least significant digit is the most recent entry.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   Defined     : a held key re-accepts its digit every REPEAT_CYCLES cycles.
//   Not defined : exactly one accept per press. REPEAT_CYCLES is unused.
module keypad_bcd_entry #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [9:0]                   key,
    input  logic                         clear,
    output logic                         digit_valid,
    output logic [3:0]                   digit,
    input  logic                         digit_ready,
    output logic [4*DIGITS-1:0]          bcd_value,
    output logic [$clog2(DIGITS+1)-1:0]  ndigits,
    output logic                         ovf,
    output logic                         multi_err,
    output logic                         overrun
);

    localparam int NW = $clog2(DIGITS + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [NW-1:0] DIG_MAX = NW'(DIGITS);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Out-of-range parameters show up as this named scope in the hierarchy.
    if (DIGITS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_illegal_parameters
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEB_PRS = 3'd1,
        HELD    = 3'd2,
        DEB_REL = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    // Index of the single active key line; only meaningful when one-hot.
    function automatic logic [3:0] encode_key(input logic [9:0] k);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [9:0] key_meta_q;
    logic [9:0] keys_q;

    // Two-flop synchroniser on the raw key lines.
    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= '0;
            keys_q     <= '0;
        end else begin
            key_meta_q <= key;
            keys_q     <= key_meta_q;
        end
    end

    logic       keys_zero;
    logic       keys_onehot;
    logic       keys_multi;
    logic [3:0] keys_code;

    assign keys_zero   = (keys_q == 10'd0);
    assign keys_onehot = !keys_zero && ((keys_q & (keys_q - 10'd1)) == 10'd0);
    assign keys_multi  = !keys_zero && !keys_onehot;
    assign keys_code   = encode_key(keys_q);

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    code_q, code_d;
    logic          accept;
    logic          multi_d;
    logic          multi_err_q;

    assign cnt_inc = cnt_q + CNT_ONE;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_ONE = RW'(1);

    logic [RW-1:0] rep_q, rep_d;
    logic [RW-1:0] rep_inc;

    assign rep_inc = rep_q + REP_ONE;

    // Repeat counter; holds zero outside HELD so each entry starts a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    // FSM state, debounce counter, latched code and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= 4'd0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            multi_err_q <= multi_d;
        end
    end

    // Next-state logic; cnt counts consecutive stable samples including the first.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        accept  = 1'b0;
        multi_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (keys_multi) begin
                    multi_d = 1'b1;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end else if (keys_onehot) begin
                    code_d = keys_code;
                    if (CNT_ONE == DEB_MAX) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = DEB_PRS;
                    end
                end
            end

            DEB_PRS: begin
                if (keys_zero) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (keys_multi) begin
                    multi_d = 1'b1;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end else if (keys_code == code_q) begin
                    if (cnt_inc == DEB_MAX) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    // A different single key restarts the debounce window.
                    code_d = keys_code;
                    cnt_d  = CNT_ONE;
                end
            end

            HELD: begin
                if (keys_zero) begin
                    if (CNT_ONE == DEB_MAX) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = DEB_REL;
                    end
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_inc == REP_MAX) begin
                        accept = 1'b1;
                        rep_d  = '0;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
            end

            DEB_REL: begin
                if (!keys_zero) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_inc == DEB_MAX) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            LOCKED: begin
                if (!keys_zero) begin
                    cnt_d = '0;
                end else if (cnt_inc == DEB_MAX) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Entry register and flags
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS+3:0] bcd_shift;
    logic [NW-1:0]       ndigits_q;
    logic                ovf_q;
    logic                overrun_q;
    logic                digit_valid_q;
    logic [3:0]          digit_q;

    // Widened so the shift is legal for DIGITS == 1; the top digit drops off.
    assign bcd_shift = {bcd_q, code_d};

    // Entry register, digit count and sticky flags; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= '0;
            ndigits_q <= '0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            bcd_q     <= '0;
            ndigits_q <= '0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else if (accept) begin
            bcd_q <= bcd_shift[4*DIGITS-1:0];
            if (ndigits_q == DIG_MAX) begin
                ovf_q <= 1'b1;
            end else begin
                ndigits_q <= ndigits_q + NW'(1);
            end
            if (digit_valid_q && !digit_ready) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Digit stream: load on accept when the slot is free, drop on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_valid_q <= 1'b0;
            digit_q       <= 4'd0;
        end else if (accept && (!digit_valid_q || digit_ready)) begin
            digit_valid_q <= 1'b1;
            digit_q       <= code_d;
        end else if (digit_valid_q && digit_ready) begin
            digit_valid_q <= 1'b0;
        end
    end

    assign digit_valid = digit_valid_q;
    assign digit       = digit_q;
    assign bcd_value   = bcd_q;
    assign ndigits     = ndigits_q;
    assign ovf         = ovf_q;
    assign multi_err   = multi_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed testbench for keypad_bcd_entry (DIGITS=4, DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8). The auto-repeat scenario is built only with
// KEYPAD_AUTOREPEAT_EN defined.
module tb_keypad_bcd_entry;

    logic        clk;
    logic        rst_n;
    logic [9:0]  key;
    logic        clear;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        digit_ready;
    logic [15:0] bcd_value;
    logic [2:0]  ndigits;
    logic        ovf;
    logic        multi_err;
    logic        overrun;

    int total;
    int bad;
    int xfer_cnt;
    int multi_cnt;
    logic [3:0] last_digit;

    keypad_bcd_entry #(
        .DIGITS          (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key         (key),
        .clear       (clear),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .bcd_value   (bcd_value),
        .ndigits     (ndigits),
        .ovf         (ovf),
        .multi_err   (multi_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed transfers and error pulses as the consumer would see them.
    always @(posedge clk) begin
        if (digit_valid && digit_ready) begin
            xfer_cnt   <= xfer_cnt + 1;
            last_digit <= digit;
        end
        if (multi_err) multi_cnt <= multi_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [9:0] k, input int hold);
        key = k;
        cycles(hold);
        key = 10'd0;
        cycles(10);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key = 10'd0; clear = 1'b0; digit_ready = 1'b1;
        cycles(3);
        total++; if (digit_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", digit_valid); end
        total++; if (digit !== 4'd0) begin bad++; $display("FAIL reset_digit got=%0h exp=0", digit); end
        total++; if (bcd_value !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%0h exp=0", bcd_value); end
        total++; if ({ndigits, ovf, multi_err, overrun} !== 6'd0) begin bad++; $display("FAIL reset_flags got=%0h exp=0", {ndigits, ovf, multi_err, overrun}); end
        rst_n = 1'b1;
        cycles(2);
    endtask

    // Single press of 3 with exact latency and one-cycle handshake.
    task automatic test_single_press();
        int x0;
        x0 = xfer_cnt;
        key = 10'h008;
        cycles(5);
        total++; if (digit_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%0h exp=0", digit_valid); end
        cycles(1);
        total++; if (digit_valid !== 1'b1 || digit !== 4'd3) begin bad++; $display("FAIL latency got=%0h/%0h exp=1/3", digit_valid, digit); end
        cycles(1);
        total++; if (digit_valid !== 1'b0) begin bad++; $display("FAIL handshake_drop got=%0h exp=0", digit_valid); end
        cycles(3);
        key = 10'd0;
        cycles(10);
        total++; if (xfer_cnt - x0 !== 1 || last_digit !== 4'd3) begin bad++; $display("FAIL single_xfer got=%0d/%0h exp=1/3", xfer_cnt - x0, last_digit); end
        total++; if (bcd_value !== 16'h0003 || ndigits !== 3'd1) begin bad++; $display("FAIL single_reg got=%0h/%0d exp=0003/1", bcd_value, ndigits); end
    endtask

    // One-cycle drop restarts debounce; a short press emits nothing.
    task automatic test_glitch();
        int x0;
        x0 = xfer_cnt;
        key = 10'h020;
        cycles(2);
        key = 10'd0;
        cycles(1);
        key = 10'h020;
        cycles(5);
        total++; if (digit_valid !== 1'b0 || xfer_cnt != x0) begin bad++; $display("FAIL glitch_early got=%0h/%0d exp=0/0", digit_valid, xfer_cnt - x0); end
        cycles(1);
        total++; if (digit_valid !== 1'b1 || digit !== 4'd5) begin bad++; $display("FAIL glitch_restart got=%0h/%0h exp=1/5", digit_valid, digit); end
        cycles(2);
        key = 10'd0;
        cycles(10);
        x0 = xfer_cnt;
        press(10'h040, 3);
        total++; if (xfer_cnt != x0) begin bad++; $display("FAIL short_press got=%0d exp=0", xfer_cnt - x0); end
        total++; if (bcd_value !== 16'h0035 || ndigits !== 3'd2) begin bad++; $display("FAIL glitch_reg got=%0h/%0d exp=0035/2", bcd_value, ndigits); end
    endtask

    // Async reset in the middle of a debounce drops everything.
    task automatic test_reset_mid();
        int x0;
        x0 = xfer_cnt;
        key = 10'h040;
        cycles(4);
        rst_n = 1'b0;
        key = 10'd0;
        cycles(2);
        rst_n = 1'b1;
        cycles(10);
        total++; if (xfer_cnt != x0 || digit_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_stream got=%0d/%0h exp=0/0", xfer_cnt - x0, digit_valid); end
        total++; if (bcd_value !== 16'h0000 || ndigits !== 3'd0) begin bad++; $display("FAIL reset_mid_reg got=%0h/%0d exp=0/0", bcd_value, ndigits); end
    endtask

    // Five entries into four digits: MSD drops, count saturates, ovf sets.
    task automatic test_overflow();
        press(10'h002, 8);
        press(10'h004, 8);
        press(10'h008, 8);
        press(10'h010, 8);
        total++; if (bcd_value !== 16'h1234 || ndigits !== 3'd4 || ovf !== 1'b0) begin bad++; $display("FAIL full_reg got=%0h/%0d/%0h exp=1234/4/0", bcd_value, ndigits, ovf); end
        press(10'h020, 8);
        total++; if (bcd_value !== 16'h2345 || ndigits !== 3'd4 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_reg got=%0h/%0d/%0h exp=2345/4/1", bcd_value, ndigits, ovf); end
        pulse_clear();
        total++; if (bcd_value !== 16'h0000 || ndigits !== 3'd0 || ovf !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL clear_all got=%0h/%0d/%0h/%0h exp=0/0/0/0", bcd_value, ndigits, ovf, overrun); end
    endtask

    // Two keys at once: one error pulse, lockout until four zero samples.
    task automatic test_multi();
        int x0;
        int m0;
        x0 = xfer_cnt;
        m0 = multi_cnt;
        key = 10'h011;
        cycles(3);
        key = 10'h010;
        cycles(10);
        key = 10'd0;
        cycles(2);
        key = 10'h010;
        cycles(10);
        total++; if (multi_cnt - m0 !== 1) begin bad++; $display("FAIL multi_pulse got=%0d exp=1", multi_cnt - m0); end
        total++; if (xfer_cnt != x0) begin bad++; $display("FAIL locked_ignore got=%0d exp=0", xfer_cnt - x0); end
        key = 10'd0;
        cycles(8);
        press(10'h010, 8);
        total++; if (xfer_cnt - x0 !== 1 || last_digit !== 4'd4) begin bad++; $display("FAIL unlock_press got=%0d/%0h exp=1/4", xfer_cnt - x0, last_digit); end
        total++; if (bcd_value !== 16'h0004 || ndigits !== 3'd1) begin bad++; $display("FAIL unlock_reg got=%0h/%0d exp=0004/1", bcd_value, ndigits); end
    endtask

    // Stalled consumer: first digit held, second dropped from stream, overrun.
    task automatic test_overrun();
        int x0;
        pulse_clear();
        digit_ready = 1'b0;
        x0 = xfer_cnt;
        press(10'h080, 8);
        total++; if (digit_valid !== 1'b1 || digit !== 4'd7 || overrun !== 1'b0) begin bad++; $display("FAIL stall_first got=%0h/%0h/%0h exp=1/7/0", digit_valid, digit, overrun); end
        press(10'h100, 8);
        total++; if (digit !== 4'd7 || overrun !== 1'b1) begin bad++; $display("FAIL stall_second got=%0h/%0h exp=7/1", digit, overrun); end
        total++; if (bcd_value !== 16'h0078 || ndigits !== 3'd2) begin bad++; $display("FAIL stall_reg got=%0h/%0d exp=0078/2", bcd_value, ndigits); end
        digit_ready = 1'b1;
        cycles(3);
        total++; if (xfer_cnt - x0 !== 1 || last_digit !== 4'd7 || digit_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%0d/%0h/%0h exp=1/7/0", xfer_cnt - x0, last_digit, digit_valid); end
    endtask

    // Clear on the accept edge: registers clear, stream still takes the digit.
    task automatic test_clear_vs_accept();
        key = 10'h004;
        cycles(5);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        total++; if (digit_valid !== 1'b1 || digit !== 4'd2) begin bad++; $display("FAIL clr_acc_stream got=%0h/%0h exp=1/2", digit_valid, digit); end
        total++; if (bcd_value !== 16'h0000 || ndigits !== 3'd0 || overrun !== 1'b0) begin bad++; $display("FAIL clr_acc_reg got=%0h/%0d/%0h exp=0/0/0", bcd_value, ndigits, overrun); end
        key = 10'd0;
        cycles(10);
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    // Held 9 repeats every 8 cycles after the first accept.
    task automatic test_autorepeat();
        int x0;
        pulse_clear();
        x0 = xfer_cnt;
        key = 10'h200;
        cycles(6);
        cycles(26);
        key = 10'd0;
        cycles(12);
        total++; if (xfer_cnt - x0 !== 4 || last_digit !== 4'd9) begin bad++; $display("FAIL repeat_count got=%0d/%0h exp=4/9", xfer_cnt - x0, last_digit); end
        total++; if (bcd_value !== 16'h9999 || ndigits !== 3'd4) begin bad++; $display("FAIL repeat_reg got=%0h/%0d exp=9999/4", bcd_value, ndigits); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        xfer_cnt = 0;
        multi_cnt = 0;
        last_digit = 4'd0;
        test_reset();
        test_single_press();
        test_glitch();
        test_reset_mid();
        test_overflow();
        test_multi();
        test_overrun();
        test_clear_vs_accept();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
